// File: rtl/lii_wrr_arbiter.sv
// Weighted round-robin arbiter with multi-beat packet locking for a router output port.
// Grant is combinational from registered rotation/lock state; state moves only on accepted beats.
module lii_wrr_arbiter #(
    parameter int N       = 4,
    parameter int WW      = 4,
    parameter bit LOCK_EN = 1'b1,
    localparam int PW     = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    req_last,
    input  logic [N*WW-1:0] weight,
    input  logic            accept,
    output logic [N-1:0]    gnt,
    output logic            gnt_v,
    output logic [PW-1:0]   gnt_idx,
    output logic            locked
);
    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

    lock_e          lock_st, lock_nx;
    logic [PW-1:0]  ptr, ptr_nx, lock_idx, lock_idx_nx;
    logic [WW-1:0]  cnt, cnt_nx;
    logic [PW-1:0]  win, ptr_inc;
    logic           found, xfer, done;
    logic [WW-1:0]  w_raw, w_eff;

    // Circular scan from ptr; descending k so the closest requester to the head wins.
    always_comb begin
        int idx;
        idx   = 0;
        win   = '0;
        found = 1'b0;
        for (int k = N-1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) begin
                win   = PW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        if (!rst) begin
            if (lock_st == LOCKED) begin
                if (req[lock_idx]) begin
                    gnt[lock_idx] = 1'b1;
                    gnt_idx       = lock_idx;
                end
            end else if (found) begin
                gnt[win] = 1'b1;
                gnt_idx  = win;
            end
        end
    end

    assign gnt_v = |gnt;

    // Also flags the opening beat of a multi-beat packet, before the lock register is set.
    assign locked = !rst && ((lock_st == LOCKED) || (gnt_v && LOCK_EN && !req_last[gnt_idx]));

    assign w_raw   = weight[int'(gnt_idx)*WW +: WW];
    assign w_eff   = (w_raw == '0) ? WW'(1) : w_raw;
    assign ptr_inc = (gnt_idx == PW'(N-1)) ? '0 : gnt_idx + PW'(1);
    assign xfer    = gnt_v && accept;
    assign done    = xfer && (!LOCK_EN || req_last[gnt_idx]);

    always_comb begin
        lock_nx     = lock_st;
        lock_idx_nx = lock_idx;
        ptr_nx      = ptr;
        cnt_nx      = cnt;
        if (done) begin
            lock_nx = UNLOCKED;
            if (gnt_idx == ptr) begin
                if ((WW+1)'(cnt) + (WW+1)'(1) < (WW+1)'(w_eff)) begin
                    cnt_nx = cnt + WW'(1);
                end else begin
                    ptr_nx = ptr_inc;
                    cnt_nx = '0;
                end
            end else if (w_eff > WW'(1)) begin
                // Idle head was skipped: the winner takes over the head, one packet already served.
                ptr_nx = gnt_idx;
                cnt_nx = WW'(1);
            end else begin
                ptr_nx = ptr_inc;
                cnt_nx = '0;
            end
        end else if (xfer) begin
            lock_nx     = LOCKED;
            lock_idx_nx = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_st  <= UNLOCKED;
            lock_idx <= '0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            lock_st  <= lock_nx;
            lock_idx <= lock_idx_nx;
            ptr      <= ptr_nx;
            cnt      <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_lii_wrr_arbiter.sv
// Bench for lii_wrr_arbiter: directed vector table plus randomized run against a rotation model.
module tb_lii_wrr_arbiter;
    localparam int N  = 4;
    localparam int WW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_last;
    logic [N*WW-1:0] weight;
    logic            accept;
    logic [N-1:0]    gnt_a, gnt_b;
    logic            gv_a, gv_b, lk_a, lk_b;
    logic [1:0]      gi_a, gi_b;

    int errors = 0;
    int checks = 0;

    lii_wrr_arbiter #(.N(N), .WW(WW), .LOCK_EN(1'b1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last), .weight(weight), .accept(accept),
        .gnt(gnt_a), .gnt_v(gv_a), .gnt_idx(gi_a), .locked(lk_a));

    lii_wrr_arbiter #(.N(N), .WW(WW), .LOCK_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .req(req), .req_last(req_last), .weight(weight), .accept(accept),
        .gnt(gnt_b), .gnt_v(gv_b), .gnt_idx(gi_b), .locked(lk_b));

    always #5 clk = ~clk;

    // Reference model: index 0 follows the locking instance, index 1 the non-locking one.
    int m_ptr[2]  = '{0, 0};
    int m_cnt[2]  = '{0, 0};
    bit m_lock[2] = '{0, 0};
    int m_lidx[2] = '{0, 0};

    function automatic int mgrant(int i);
        if (rst) return -1;
        if (m_lock[i]) return req[m_lidx[i]] ? m_lidx[i] : -1;
        for (int k = 0; k < N; k++)
            if (req[(m_ptr[i] + k) % N]) return (m_ptr[i] + k) % N;
        return -1;
    endfunction

    function automatic logic [7:0] mexp(int i);
        int w;
        logic [3:0] g;
        logic lk;
        w  = mgrant(i);
        g  = (w >= 0) ? 4'(1 << w) : 4'b0;
        lk = !rst && (m_lock[i] || (w >= 0 && i == 0 && !req_last[w]));
        return {g, w >= 0, (w >= 0) ? 2'(w) : 2'b0, lk};
    endfunction

    task automatic mupdate(int i);
        int w, wt;
        w = mgrant(i);
        if (rst) begin
            m_ptr[i] <= 0; m_cnt[i] <= 0; m_lock[i] <= 0; m_lidx[i] <= 0;
        end else if (w >= 0 && accept) begin
            if (i == 0 && !req_last[w]) begin
                m_lock[i] <= 1; m_lidx[i] <= w;
            end else begin
                wt = int'(weight[w*WW +: WW]);
                if (wt == 0) wt = 1;
                m_lock[i] <= 0;
                if (w == m_ptr[i]) begin
                    if (m_cnt[i] + 1 < wt) m_cnt[i] <= m_cnt[i] + 1;
                    else begin m_ptr[i] <= (w + 1) % N; m_cnt[i] <= 0; end
                end else if (wt > 1) begin
                    m_ptr[i] <= w; m_cnt[i] <= 1;
                end else begin
                    m_ptr[i] <= (w + 1) % N; m_cnt[i] <= 0;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        mupdate(0);
        mupdate(1);
    end

    typedef struct {
        bit         sel;
        bit         r;
        logic [3:0] rq, rl;
        logic [15:0] wt;
        bit         acc;
        int         idx;
        bit         v;
        bit         lk;
    } vec_t;
    vec_t tbl[$];

    task automatic add(bit sel, bit r, logic [3:0] rq, logic [3:0] rl, logic [15:0] wt,
                       bit acc, int idx, bit v, bit lk);
        vec_t t;
        t.sel = sel; t.r = r; t.rq = rq; t.rl = rl; t.wt = wt;
        t.acc = acc; t.idx = idx; t.v = v; t.lk = lk;
        tbl.push_back(t);
    endtask

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {gnt,v,idx,locked}=%b expected %b", nm, act, exp);
        end
    endtask

    initial begin
        int wseq[9] = '{0, 0, 0, 1, 2, 3, 0, 0, 0};
        int bseq[4] = '{0, 1, 0, 1};
        logic [3:0] g;
        logic [7:0] act, exp;

        // Reset state, plain round robin
        add(0, 1, 4'hF, 4'hF, 16'h1111, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 0, 4'hF, 4'hF, 16'h1111, 1, k % 4, 1, 0);
        // Weighted: requester 0 holds the head for three packets
        add(0, 1, 4'hF, 4'hF, 16'h1113, 1, 0, 0, 0);
        for (int k = 0; k < 9; k++) add(0, 0, 4'hF, 4'hF, 16'h1113, 1, wseq[k], 1, 0);
        // Three-beat packet with a stalled beat
        add(0, 1, 4'h3, 4'h0, 16'h1111, 1, 0, 0, 0);
        add(0, 0, 4'h3, 4'h0, 16'h1111, 1, 0, 1, 1);
        add(0, 0, 4'h3, 4'h0, 16'h1111, 0, 0, 1, 1);
        add(0, 0, 4'h3, 4'h0, 16'h1111, 1, 0, 1, 1);
        add(0, 0, 4'h3, 4'h1, 16'h1111, 1, 0, 1, 1);
        add(0, 0, 4'h3, 4'h3, 16'h1111, 1, 1, 1, 0);
        // Idle head at ptr=2 is skipped
        add(0, 1, 4'hF, 4'hF, 16'h1111, 1, 0, 0, 0);
        add(0, 0, 4'hF, 4'hF, 16'h1111, 1, 0, 1, 0);
        add(0, 0, 4'hF, 4'hF, 16'h1111, 1, 1, 1, 0);
        add(0, 0, 4'h1, 4'hF, 16'h1111, 1, 0, 1, 0);
        add(0, 0, 4'h3, 4'hF, 16'h1111, 1, 1, 1, 0);
        // Reset while locked on requester 2
        add(0, 1, 4'hF, 4'hF, 16'h1111, 1, 0, 0, 0);
        add(0, 0, 4'hF, 4'hF, 16'h1111, 1, 0, 1, 0);
        add(0, 0, 4'hF, 4'hF, 16'h1111, 1, 1, 1, 0);
        add(0, 0, 4'h4, 4'h0, 16'h1111, 1, 2, 1, 1);
        add(0, 1, 4'h5, 4'h0, 16'h1111, 1, 0, 0, 0);
        add(0, 0, 4'h5, 4'hF, 16'h1111, 1, 0, 1, 0);
        // Weight 0 on the non-locking instance
        add(1, 1, 4'h3, 4'h0, 16'h1110, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) add(1, 0, 4'h3, 4'h0, 16'h1110, 1, bseq[k], 1, 0);

        rst = 1'b1; req = '0; req_last = '0; weight = '0; accept = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[j]) begin
            rst = tbl[j].r; req = tbl[j].rq; req_last = tbl[j].rl;
            weight = tbl[j].wt; accept = tbl[j].acc;
            #1;
            act = tbl[j].sel ? {gnt_b, gv_b, gi_b, lk_b} : {gnt_a, gv_a, gi_a, lk_a};
            g   = tbl[j].v ? 4'(1 << tbl[j].idx) : 4'b0;
            exp = {g, tbl[j].v, tbl[j].v ? 2'(tbl[j].idx) : 2'b0, tbl[j].lk};
            chk($sformatf("vec%0d", j), act, exp);
            @(posedge clk); #1;
        end

        // Randomized traffic against the model, both instances
        rst = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 59) == 0);
            req      = 4'($urandom);
            req_last = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            weight   = 16'($urandom) & 16'h3333;
            accept   = ($urandom_range(0, 3) != 0);
            #1;
            chk($sformatf("rnd_a%0d", c), {gnt_a, gv_a, gi_a, lk_a}, mexp(0));
            chk($sformatf("rnd_b%0d", c), {gnt_b, gv_b, gi_b, lk_b}, mexp(1));
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lii_wrr_arbiter.md
Name: lii_wrr_arbiter

Overview:
- N-input weighted round-robin arbiter with packet locking, for the router output-port path.
- Each requester may hold the head of the rotation for up to weight[i] consecutive packets.
- A multi-beat packet keeps its grant from first to last beat.
- Grant is combinational from registered state; state advances only on accepted beats.

Parameters:
- N, 4, number of requesters (>=2).
- WW, 4, width of each per-requester weight field.
- LOCK_EN, 1, 1 = hold grant until req_last beat; 0 = every accepted beat is a complete packet.
- PW (local), $clog2(N), index width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req  input  N  request vector.
- req_last  input  N  bit i marks the current beat of requester i as the last beat of its packet.
- weight  input  N*WW  field i is bits [i*WW +: WW]; packets per turn for requester i; 0 is treated as 1.
- accept  input  1  downstream takes the granted beat this cycle.
- gnt  output  N  one-hot grant, or all zeros.
- gnt_v  output  1  equals |gnt.
- gnt_idx  output  PW  index of the granted requester; 0 when gnt_v=0.
- locked  output  1  arbiter is mid-packet.

Behaviour:
- State registers:
  - ptr (PW): rotation head.
  - cnt (WW): packets already served for the head.
  - lock_st: UNLOCKED or LOCKED.
  - lock_idx (PW): owner of the locked packet.
- Reset (synchronous, rst=1 at clk edge): ptr=0, cnt=0, lock_st=UNLOCKED, lock_idx=0.
- While rst=1, gnt=0, gnt_v=0, gnt_idx=0, locked=0.
- UNLOCKED grant:
  - Scan req from ptr upward, modulo N; the first set bit w wins.
  - gnt=onehot(w), gnt_idx=w.
  - If req=0, then gnt=0.
- LOCKED grant:
  - gnt=onehot(lock_idx) only if req[lock_idx]=1; otherwise gnt=0.
  - All other requests are masked.
  - locked=1.
- Beat transfer = gnt_v & accept. With no transfer, no state changes (accept low stalls indefinitely).
- Packet completion = transfer & (req_last[w] | LOCK_EN==0), where w is the granted index.
- Transfer without completion (LOCK_EN=1 only):
  - From UNLOCKED: go to LOCKED, lock_idx<=w.
  - From LOCKED: stay LOCKED.
  - ptr and cnt are unchanged.
- Rotation update on completion. W = max(weight[w],1), sampled in the completion cycle.
  - If w==ptr:
    - if cnt+1 < W: cnt<=cnt+1, ptr unchanged;
    - else ptr<=(w+1)%N, cnt<=0.
  - If w!=ptr (head was idle and skipped):
    - if W>1: ptr<=w, cnt<=1;
    - else ptr<=(w+1)%N, cnt<=0.
  - lock_st<=UNLOCKED.
- A single-beat packet (req_last=1 on the first beat) never enters LOCKED.
- Wrap: ptr increments modulo N; for N not a power of 2, ptr never holds a value >=N.
- Head drops req while cnt>0: it is skipped; the next completion by another requester w follows the w!=ptr rule and resets cnt.
- Weight changes take effect at the next completion; cnt is not clipped retroactively.
- req_last of non-granted requesters is ignored.
- Reset during LOCKED: the lock is abandoned; the next cycle arbitrates from ptr=0.
- Latency: grant is visible in the same cycle as req (combinational); state updates at the next clk edge.

Test Plan:
- Plain RR: N=4, all weights=1, req=1111, req_last=1111, accept=1 -> gnt_idx sequence 0,1,2,3,0,1; locked stays 0.
- Weighted: weight={1,1,1,3} (field0=3), req=1111, req_last=1111, accept=1 -> gnt_idx 0,0,0,1,2,3,0,0,0.
- Packet lock: req=0011 after reset; requester 0 sends 3 beats with req_last[0] on beat 3; accept pattern 1,0,1,1 ->
  - gnt=0001 and locked=1 across all 4 cycles, including the stalled cycle;
  - 5th cycle gnt=0010, locked=0.
- Skip idle head: reach ptr=2 via RR; then req=0001, weight0=1 -> gnt_idx=0; after completion ptr=1 (next req=0011 grants 1).
- Weight 0 and LOCK_EN=0: weight0=0, LOCK_EN=0 instance, req=0011, req_last=0000, accept=1 -> grants alternate 0,1,0,1; locked never asserts.
- Reset mid-packet: enter LOCKED on requester 2 (ptr=2); assert rst one cycle with req=0101 -> during rst gnt=0; next cycle gnt=0001, locked=0, ptr=0.
